// File: rtl/uartrx_pkg.sv
// Shared types and constants for the uartrx FIFO controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uartrx_pkg;

    localparam int DataWidth = 8;

    // Receiver handshake sequencer states.
    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Arm     = 2'd1,
        Release = 2'd2
    } uartrx_ctrl_state_e;

    // Saturating increment for the 8-bit overrun counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered storage and extended-pointer full/empty detection.
// Latency: push at edge T is visible on o_pop_dat/!o_empty after T; no bypass path.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop ignored when empty.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_push/_dat     write request and byte
//   i_pop           advance read pointer (head consumed)
//   o_pop_dat       head byte (0 after reset)
//   o_full/o_empty  occupancy flags
//   o_level         occupancy 0..Depth
module uart_byte_fifo
    import uartrx_pkg::*;
#(
    parameter int Depth = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic [DataWidth-1:0] i_push_dat,
    input  logic                 i_pop,
    output logic [DataWidth-1:0] o_pop_dat,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [$clog2(Depth):0] o_level
);

    localparam int AW = $clog2(Depth);
    localparam int PW = AW + 1;

    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [DataWidth-1:0] r_mem [Depth];
    logic                 w_do_push;
    logic                 w_do_pop;

    // Pointers carry one extra wrap bit: equal means empty, differing only in the MSB means full.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = ((r_wr_ptr ^ r_rd_ptr) == PW'(Depth));
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

    assign w_do_pop  = i_pop && !o_empty;
    // When full, the slot being written is the one being popped this cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/uartrx_fifo_ctrl.sv
// Sequences the uartrx go/dr handshake, buffers received bytes in a FIFO, counts dropped bytes.
// Latency: urx_dr sampled at edge T -> byte at FIFO head with rd_valid=1 after T.
// Backpressure: full FIFO drops the byte and counts an overrun, or (StallWhenFull=1) holds urx_go low.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              arm the receiver
//   urx_go/urx_dr/urx_data  handshake with uartrx
//   rd_data/rd_valid/rd_ready  valid/ready read port (pop on valid && ready)
//   level               FIFO occupancy
//   overrun_cnt         saturating dropped-byte count; clear_overrun zeroes it
module uartrx_fifo_ctrl
    import uartrx_pkg::*;
#(
    parameter int Depth         = 16,
    parameter bit StallWhenFull = 1'b0
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic                   urx_go,
    input  logic [DataWidth-1:0]   urx_data,
    input  logic                   urx_dr,
    output logic [DataWidth-1:0]   rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(Depth):0] level,
    output logic [7:0]             overrun_cnt,
    input  logic                   clear_overrun
);

    uartrx_ctrl_state_e r_state;
    uartrx_ctrl_state_e w_state_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_capture;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [7:0]         r_overrun_cnt;

    assign rd_valid    = !w_empty;
    assign w_pop       = rd_valid && rd_ready;
    // A byte is only taken while go is high; dr in other states belongs to a discarded frame.
    assign w_capture   = (r_state == Arm) && urx_dr;
    assign w_push      = w_capture && (!w_full || w_pop);
    assign w_drop      = w_capture && !w_push;
    assign overrun_cnt = r_overrun_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= Idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        urx_go      = 1'b0;
        case (r_state)
            Idle: begin
                // Waiting for dr low guarantees the previous frame's flag has cleared.
                if (enable && (!StallWhenFull || !w_full) && !urx_dr) begin
                    w_state_nxt = Arm;
                end
            end
            Arm: begin
                urx_go = 1'b1;
                if (urx_dr) begin
                    w_state_nxt = Release;
                end else if (!enable || (StallWhenFull && w_full)) begin
                    w_state_nxt = Idle;
                end
            end
            Release: begin
                if (!urx_dr) begin
                    w_state_nxt = Idle;
                end
            end
            default: begin
                w_state_nxt = Idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun_cnt <= '0;
        end else if (clear_overrun) begin
            r_overrun_cnt <= '0;
        end else if (w_drop) begin
            r_overrun_cnt <= sat_inc8(r_overrun_cnt);
        end
    end

    uart_byte_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (urx_data),
        .i_pop      (w_pop),
        .o_pop_dat  (rd_data),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (level)
    );

endmodule

// File: tb/tb_uartrx_fifo_ctrl.sv
// Bench for uartrx_fifo_ctrl: vector table, directed corner sequences, randomized run vs queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uartrx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] urx_data = 8'h00;
    logic       urx_dr = 1'b0;
    logic       rd_ready = 1'b0;
    logic       clear_overrun = 1'b0;

    logic       go0, rdv0, go1, rdv1;
    logic [7:0] rdd0, rdd1, ovr0, ovr1;
    logic [4:0] lvl0, lvl1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uartrx_fifo_ctrl #(.Depth(16), .StallWhenFull(1'b0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .urx_go(go0), .urx_data(urx_data),
        .urx_dr(urx_dr), .rd_data(rdd0), .rd_valid(rdv0), .rd_ready(rd_ready),
        .level(lvl0), .overrun_cnt(ovr0), .clear_overrun(clear_overrun)
    );

    uartrx_fifo_ctrl #(.Depth(16), .StallWhenFull(1'b1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .urx_go(go1), .urx_data(urx_data),
        .urx_dr(urx_dr), .rd_data(rdd1), .rd_valid(rdv1), .rd_ready(rd_ready),
        .level(lvl1), .overrun_cnt(ovr1), .clear_overrun(clear_overrun)
    );

    typedef struct {
        logic       en;
        logic       dr;
        logic [7:0] d;
        logic       rdy;
        logic       clr;
        logic       go;
        logic       vld;
        logic [4:0] lvl;
        logic [7:0] head;
        logic [7:0] ovr;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic en, input logic dr, input logic [7:0] d,
                        input logic rdy, input logic clr);
        enable        = en;
        urx_dr        = dr;
        urx_data      = d;
        rd_ready      = rdy;
        clear_overrun = clr;
        @(posedge clk);
        #1;
    endtask

    // One uartrx byte: wait (bounded) for go, present dr for one cycle, release.
    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        while (go0 !== 1'b1 && n < 10) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk("send_arm", {31'd0, go0}, 32'd1);
        step(1'b1, 1'b1, d, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] q [$];
        int         mst;
        int         movr;
        logic       en, dr, rdy, clr;
        logic [7:0] d;
        int         rdy_pct;

        // en dr d rdy clr | go vld lvl head ovr
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'hA5, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'hA5, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'hA5, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 8'd0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'd0};
        tbl[7]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'd0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 8'd0};
        tbl[9]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 8'h3C, 8'd0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_go", {31'd0, go0}, 32'd0);
        chk("rst_valid", {31'd0, rdv0}, 32'd0);
        chk("rst_level", {27'd0, lvl0}, 32'd0);
        chk("rst_ovr", {24'd0, ovr0}, 32'd0);
        chk("rst_rdata", {24'd0, rdd0}, 32'd0);
        chk("rst_go_stall", {31'd0, go1}, 32'd0);
        rst = 1'b0;

        // Vector table: single byte, dr-held release, dr-outside-Arm ignore, enable drop in Arm
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].en, tbl[i].dr, tbl[i].d, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("vec%0d_go", i), {31'd0, go0}, {31'd0, tbl[i].go});
            chk($sformatf("vec%0d_valid", i), {31'd0, rdv0}, {31'd0, tbl[i].vld});
            chk($sformatf("vec%0d_level", i), {27'd0, lvl0}, {27'd0, tbl[i].lvl});
            chk($sformatf("vec%0d_ovr", i), {24'd0, ovr0}, {24'd0, tbl[i].ovr});
            if (tbl[i].vld) chk($sformatf("vec%0d_head", i), {24'd0, rdd0}, {24'd0, tbl[i].head});
        end

        // Fill to 16, then a 17th byte overruns
        for (int i = 0; i < 16; i++) send(8'(i));
        chk("fill_level", {27'd0, lvl0}, 32'd16);
        chk("fill_head", {24'd0, rdd0}, 32'h00);
        chk("fill_level_stall", {27'd0, lvl1}, 32'd16);
        send(8'h10);
        chk("drop_ovr", {24'd0, ovr0}, 32'd1);
        chk("drop_level", {27'd0, lvl0}, 32'd16);
        chk("drop_head", {24'd0, rdd0}, 32'h00);
        chk("stall_go_low", {31'd0, go1}, 32'd0);
        chk("stall_ovr", {24'd0, ovr1}, 32'd0);

        // Full FIFO: pop coincident with push of 0x77
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_arm_go", {31'd0, go0}, 32'd1);
        chk("stall_still_low", {31'd0, go1}, 32'd0);
        step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        chk("pp_level", {27'd0, lvl0}, 32'd16);
        chk("pp_ovr", {24'd0, ovr0}, 32'd1);
        chk("pp_head", {24'd0, rdd0}, 32'h01);
        chk("stall_pop_level", {27'd0, lvl1}, 32'd15);
        chk("stall_pop_head", {24'd0, rdd1}, 32'h01);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("stall_rearm_go", {31'd0, go1}, 32'd1);
        chk("stall_rearm_valid", {31'd0, rdv1}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_head", i), {24'd0, rdd0}, (i < 15) ? 32'(i + 1) : 32'h77);
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_level", {27'd0, lvl0}, 32'd0);
        chk("drain_valid", {31'd0, rdv0}, 32'd0);

        // Enable falls while armed; the frame's dr then arrives and must be ignored
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("en_arm_go", {31'd0, go0}, 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("en_drop_go", {31'd0, go0}, 32'd0);
        step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("en_drop_level", {27'd0, lvl0}, 32'd0);
        chk("en_drop_valid", {31'd0, rdv0}, 32'd0);
        chk("en_drop_go2", {31'd0, go0}, 32'd0);

        // Reset while armed with 3 bytes queued (overrun count still nonzero)
        send(8'hC1);
        send(8'hC2);
        send(8'hC3);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_go", {31'd0, go0}, 32'd1);
        chk("pre_rst_level", {27'd0, lvl0}, 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_go", {31'd0, go0}, 32'd0);
        chk("mid_rst_valid", {31'd0, rdv0}, 32'd0);
        chk("mid_rst_level", {27'd0, lvl0}, 32'd0);
        chk("mid_rst_ovr", {24'd0, ovr0}, 32'd0);
        chk("mid_rst_rdata", {24'd0, rdd0}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 300 drops saturate at 255; clear coincident with a drop wins
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
        for (int i = 0; i < 254; i++) send(8'hEE);
        chk("sat_254", {24'd0, ovr0}, 32'd254);
        for (int i = 0; i < 46; i++) send(8'hEE);
        chk("sat_255", {24'd0, ovr0}, 32'd255);
        chk("sat_level", {27'd0, lvl0}, 32'd16);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
        chk("clr_drop_ovr", {24'd0, ovr0}, 32'd0);
        chk("clr_drop_head", {24'd0, rdd0}, 32'h80);

        // Randomized run against a queue model of the sequencer rules
        do_reset();
        q.delete();
        mst  = 0;
        movr = 0;
        for (int c = 0; c < 3000; c++) begin
            bit full;
            bit pop;
            bit cap;
            bit drop;
            case ((c / 500) % 3)
                0:       rdy_pct = 10;
                1:       rdy_pct = 50;
                default: rdy_pct = 90;
            endcase
            en  = ($urandom_range(9) != 0);
            dr  = ($urandom_range(9) < 4);
            d   = 8'($urandom);
            rdy = ($urandom_range(99) < rdy_pct);
            clr = ($urandom_range(49) == 0);

            full = (q.size() == 16);
            pop  = rdy && (q.size() > 0);
            cap  = (mst == 1) && dr;
            drop = 1'b0;
            if (pop) void'(q.pop_front());
            if (cap) begin
                if (!full || pop) q.push_back(d);
                else drop = 1'b1;
            end
            if (clr) movr = 0;
            else if (drop && movr < 255) movr++;
            case (mst)
                0:       if (en && !dr) mst = 1;
                1:       if (dr) mst = 2; else if (!en) mst = 0;
                default: if (!dr) mst = 0;
            endcase

            step(en, dr, d, rdy, clr);
            chk("rnd_go", {31'd0, go0}, (mst == 1) ? 32'd1 : 32'd0);
            chk("rnd_valid", {31'd0, rdv0}, (q.size() > 0) ? 32'd1 : 32'd0);
            chk("rnd_level", {27'd0, lvl0}, 32'(q.size()));
            chk("rnd_ovr", {24'd0, ovr0}, 32'(movr));
            if (q.size() > 0) chk("rnd_head", {24'd0, rdd0}, {24'd0, q[0]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
